handshake_cond_br_fifo: RTL and testbench

//  Elastic conditional branch that consumes the 1-bit result of a comparator
//  (handshake_cmpi_*) and steers a data token to a true or false successor.
//  A COND_DEPTH-entry condition FIFO lets the comparator run ahead of the data

---
 rtl/handshake_cond_br_fifo.sv | 77 +++++++
 tb/tb_handshake_cond_br_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/handshake_cond_br_fifo.sv
// Conditional branch with a small condition FIFO so the comparator can run
// ahead of the data path; the head condition steers each data token.
module handshake_cond_br_fifo #(
  parameter int unsigned DATA_TYPE  = 32,
  parameter int unsigned COND_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 condition,
  input  logic                 condition_valid,
  output logic                 condition_ready,
  input  logic [DATA_TYPE-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [DATA_TYPE-1:0] trueOut,
  output logic                 trueOut_valid,
  input  logic                 trueOut_ready,
  output logic [DATA_TYPE-1:0] falseOut,
  output logic                 falseOut_valid,
  input  logic                 falseOut_ready
);

  localparam int unsigned PTR_W = (COND_DEPTH > 1) ? $clog2(COND_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(COND_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(COND_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(COND_DEPTH);

  logic [COND_DEPTH-1:0] storage;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic head;
  logic head_valid;
  logic fire_ok;
  logic sel_ready;
  logic push;
  logic pop;

  always_comb begin
    head            = storage[rd_ptr];
    // Gating with rst keeps every handshake quiet on the first reset cycle
    head_valid      = ~rst & (count != '0);
    condition_ready = ~rst & (count < FULL_CNT);
    fire_ok         = head_valid & data_valid;
    trueOut_valid   = fire_ok & head;
    falseOut_valid  = fire_ok & ~head;
    sel_ready       = head ? trueOut_ready : falseOut_ready;
    data_ready      = fire_ok & sel_ready;
    trueOut         = data;
    falseOut        = data;
    push            = condition_valid & condition_ready;
    pop             = data_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= condition;
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_cond_br_fifo.sv
// Directed checks of the conditional branch FIFO: a depth-4 instance for the
// basic cases and a depth-3 instance for the wrap / simultaneous push-pop stream.
module tb_handshake_cond_br_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        cond, cv, cr, dv, dr, tv, tr, fv, fr;
  logic [31:0] data, tout, fout;

  logic        c3_cond, c3_cv, c3_cr, c3_dv, c3_dr, c3_tv, c3_tr, c3_fv, c3_fr;
  logic [31:0] c3_data, c3_tout, c3_fout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  handshake_cond_br_fifo #(.DATA_TYPE(32), .COND_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .condition(cond), .condition_valid(cv), .condition_ready(cr),
    .data(data), .data_valid(dv), .data_ready(dr),
    .trueOut(tout), .trueOut_valid(tv), .trueOut_ready(tr),
    .falseOut(fout), .falseOut_valid(fv), .falseOut_ready(fr)
  );

  handshake_cond_br_fifo #(.DATA_TYPE(32), .COND_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .condition(c3_cond), .condition_valid(c3_cv), .condition_ready(c3_cr),
    .data(c3_data), .data_valid(c3_dv), .data_ready(c3_dr),
    .trueOut(c3_tout), .trueOut_valid(c3_tv), .trueOut_ready(c3_tr),
    .falseOut(c3_fout), .falseOut_valid(c3_fv), .falseOut_ready(c3_fr)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  c3seq;
    logic [19:0] pat;
    int          q[$];
    int          pushed, d, cyc;
    logic        exp_cr, fire, hd, exp_dr;

    // T1: reset with all valids and readies high
    rst = 1'b1; cond = 1'b1; cv = 1'b1; dv = 1'b1; data = 32'h1234; tr = 1'b1; fr = 1'b1;
    c3_cond = 1'b0; c3_cv = 1'b0; c3_dv = 1'b0; c3_data = '0; c3_tr = 1'b1; c3_fr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check_eq("t1_cond_ready", cr, 0);
      check_eq("t1_data_ready", dr, 0);
      check_eq("t1_true_valid", tv, 0);
      check_eq("t1_false_valid", fv, 0);
    end
    rst = 1'b0; cv = 1'b0; dv = 1'b0;
    #1;
    check_eq("t1_release_cond_ready", cr, 1);
    check_eq("t1_release_data_ready", dr, 0);

    // T2: single true token, no bypass through an empty FIFO
    step();
    cv = 1'b1; cond = 1'b1; dv = 1'b1; data = 32'hDEADBEEF;
    #1;
    check_eq("t2_no_bypass_valid", tv, 0);
    check_eq("t2_no_bypass_ready", dr, 0);
    step();
    cv = 1'b0;
    #1;
    check_eq("t2_true_valid", tv, 1);
    check_eq("t2_true_data", tout, 32'hDEADBEEF);
    check_eq("t2_false_valid", fv, 0);
    check_eq("t2_data_ready", dr, 1);
    step();
    dv = 1'b0;
    #1;
    check_eq("t2_after_pop_valid", tv, 0);
    check_eq("t2_after_pop_cond_ready", cr, 1);

    // T3: conditions run ahead, then data drains them in order
    c3seq = 4'b1101;  // bit i is the i-th condition: 1,0,1,1
    for (int i = 0; i < 4; i++) begin
      cv = 1'b1; cond = c3seq[i];
      #1;
      check_eq("t3_push_ready", cr, 1);
      step();
    end
    cv = 1'b0;
    #1;
    check_eq("t3_full_ready", cr, 0);
    for (int i = 0; i < 4; i++) begin
      dv = 1'b1; data = 32'(10 + i);
      #1;
      check_eq("t3_true_valid", tv, c3seq[i]);
      check_eq("t3_false_valid", fv, !c3seq[i]);
      check_eq("t3_data_ready", dr, 1);
      check_eq("t3_out_data", c3seq[i] ? tout : fout, 10 + i);
      if (i == 0) check_eq("t3_full_pop_no_ready", cr, 0);
      step();
    end
    dv = 1'b0;
    #1;
    check_eq("t3_ready_back", cr, 1);

    // T4: false-path backpressure holds the token
    cv = 1'b1; cond = 1'b0;
    step();
    cv = 1'b0; dv = 1'b1; data = 32'd5; fr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t4_false_valid", fv, 1);
      check_eq("t4_false_data", fout, 5);
      check_eq("t4_data_ready", dr, 0);
      check_eq("t4_true_valid", tv, 0);
      step();
    end
    fr = 1'b1;
    #1;
    check_eq("t4_release_ready", dr, 1);
    step();
    dv = 1'b0;

    // T6: reset mid-operation discards queued conditions
    cv = 1'b1; cond = 1'b1;
    step();
    step();
    cv = 1'b0; rst = 1'b1;
    #1;
    check_eq("t6_rst_cond_ready", cr, 0);
    step();
    rst = 1'b0; dv = 1'b1; data = 32'd77;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("t6_empty_true_valid", tv, 0);
      check_eq("t6_empty_false_valid", fv, 0);
      check_eq("t6_empty_data_ready", dr, 0);
      step();
    end
    cv = 1'b1; cond = 1'b0;
    #1;
    check_eq("t6_new_cond_no_bypass", fv, 0);
    step();
    cv = 1'b0;
    #1;
    check_eq("t6_new_false_valid", fv, 1);
    check_eq("t6_new_true_valid", tv, 0);
    check_eq("t6_new_data_ready", dr, 1);
    step();
    dv = 1'b0;

    // T5: depth-3 stream with wrap, simultaneous push/pop and output stalls
    pat = 20'hB2E59;
    pushed = 0; d = 0; cyc = 0;
    while ((pushed < 20 || q.size() > 0) && cyc < 100) begin
      c3_cv   = (pushed < 20);
      c3_cond = (pushed < 20) ? pat[pushed] : 1'b0;
      c3_dv   = (d < 20);
      c3_data = 32'(100 + d);
      c3_fr   = (cyc % 3) != 0;
      c3_tr   = (cyc % 4) != 1;
      #1;
      exp_cr = (q.size() < 3);
      fire   = (q.size() > 0) && c3_dv;
      hd     = fire ? q[0][0] : 1'b0;
      exp_dr = fire && (hd ? c3_tr : c3_fr);
      check_eq("t5_cond_ready", c3_cr, exp_cr);
      check_eq("t5_true_valid", c3_tv, fire && hd);
      check_eq("t5_false_valid", c3_fv, fire && !hd);
      check_eq("t5_data_ready", c3_dr, exp_dr);
      if (fire) check_eq("t5_out_data", hd ? c3_tout : c3_fout, 100 + d);
      if (exp_dr) begin
        void'(q.pop_front());
        d++;
      end
      if (c3_cv && exp_cr) begin
        q.push_back(int'(pat[pushed]));
        pushed++;
      end
      step();
      cyc++;
    end
    c3_cv = 1'b0; c3_dv = 1'b0;
    check_eq("t5_drained", (pushed == 20) && (q.size() == 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
